// File: rtl/axi_mm_intr_pkg.sv
// Shared definitions for the matrix-multiplier interrupt controller:
// register offsets, source capture modes, AXI response code and FSM states.
package axi_mm_intr_pkg;

  localparam int unsigned ADDR_GIE      = 'h00;
  localparam int unsigned ADDR_IER      = 'h04;
  localparam int unsigned ADDR_ISR      = 'h08;
  localparam int unsigned ADDR_IACK     = 'h0C;
  localparam int unsigned ADDR_IPR      = 'h10;
  localparam int unsigned ADDR_MODE     = 'h14;
  localparam int unsigned ADDR_ISET     = 'h18;
  localparam int unsigned ADDR_COAL_THR = 'h1C;
  localparam int unsigned ADDR_COAL_TMO = 'h20;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ACC  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ACC  = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi_mm_intr_coalescer.sv
// Event coalescing and the registered irq output. Pending interrupts are
// held back until enough distinct events accumulate or a timeout expires.
module axi_mm_intr_coalescer #(
  parameter int C_NUM_OF_INTR = 4,
  parameter int C_COAL_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gie,
  input  logic [C_NUM_OF_INTR-1:0] ipr,
  input  logic [C_COAL_W-1:0]      coal_thr,
  input  logic [C_COAL_W-1:0]      coal_tmo,
  output logic                     irq
);

  localparam int CW = C_COAL_W;

  logic [C_NUM_OF_INTR-1:0] ipr_prev;
  logic [CW-1:0]            evt_cnt;
  logic [CW-1:0]            tmo_cnt;
  logic                     pending;
  logic                     rise;
  logic                     fire;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign pending = |ipr;
  assign rise    = |(ipr & ~ipr_prev);

  // Release condition; the timeout term counts the current pending cycle so
  // irq lands exactly COAL_TMO cycles after IPR first goes nonzero.
  always_comb begin
    fire = (coal_thr <= CW'(1)) ||
           (evt_cnt >= coal_thr) ||
           ((coal_tmo != '0) && (sat_inc(tmo_cnt) >= coal_tmo));
  end

  // Event/timeout counters and the sticky irq register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ipr_prev <= '0;
      evt_cnt  <= '0;
      tmo_cnt  <= '0;
      irq      <= 1'b0;
    end else begin
      ipr_prev <= ipr;
      if (!pending) begin
        evt_cnt <= '0;
        tmo_cnt <= '0;
      end else begin
        if (rise) evt_cnt <= sat_inc(evt_cnt);
        if (!irq) tmo_cnt <= sat_inc(tmo_cnt);
      end
      if (irq) irq <= gie & pending;
      else     irq <= gie & pending & fire;
    end
  end

endmodule

// File: rtl/axi_mm_intr_ctrl.sv
// AXI4-Lite interrupt controller: register file, per-channel edge/level
// capture with software set/ack, and coalesced irq to the processor.
module axi_mm_intr_ctrl
  import axi_mm_intr_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_NUM_OF_INTR      = 4,
  parameter int C_COAL_W           = 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_NUM_OF_INTR-1:0]      intr_in,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          irq
);

  localparam int N  = C_NUM_OF_INTR;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int CW = C_COAL_W;

  localparam logic [AW-1:0] A_GIE  = AW'(ADDR_GIE);
  localparam logic [AW-1:0] A_IER  = AW'(ADDR_IER);
  localparam logic [AW-1:0] A_ISR  = AW'(ADDR_ISR);
  localparam logic [AW-1:0] A_IACK = AW'(ADDR_IACK);
  localparam logic [AW-1:0] A_IPR  = AW'(ADDR_IPR);
  localparam logic [AW-1:0] A_MODE = AW'(ADDR_MODE);
  localparam logic [AW-1:0] A_ISET = AW'(ADDR_ISET);
  localparam logic [AW-1:0] A_THR  = AW'(ADDR_COAL_THR);
  localparam logic [AW-1:0] A_TMO  = AW'(ADDR_COAL_TMO);

  wr_state_e     wr_state, wr_state_nxt;
  rd_state_e     rd_state, rd_state_nxt;
  logic          wr_en;
  logic          gie;
  logic [N-1:0]  ier, mode, isr, intr_prev;
  logic [N-1:0]  ipr, hw_set, iack_bits, iset_bits, isr_nxt;
  logic [CW-1:0] coal_thr, coal_tmo;
  logic [31:0]   rd_word;

  // Byte-lane merge of a write into the current register contents.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old[b*8 +: 8];
    return res;
  endfunction

  assign ipr         = isr & ier;
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  // Write FSM state register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) wr_state <= WR_IDLE;
    else              wr_state <= wr_state_nxt;
  end

  // Write FSM next state: accept address+data together, then respond.
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WR_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_nxt = WR_ACC;
      WR_ACC:  wr_state_nxt = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) wr_state_nxt = WR_IDLE;
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write FSM outputs decoded from the registered state.
  always_comb begin
    S_AXI_AWREADY = (wr_state == WR_ACC);
    S_AXI_WREADY  = (wr_state == WR_ACC);
    S_AXI_BVALID  = (wr_state == WR_RESP);
    wr_en         = (wr_state == WR_ACC);
  end

  // Read FSM state register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) rd_state <= RD_IDLE;
    else              rd_state <= rd_state_nxt;
  end

  // Read FSM next state: accept address, then present data until taken.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (S_AXI_ARVALID) rd_state_nxt = RD_ACC;
      RD_ACC:  rd_state_nxt = RD_DATA;
      RD_DATA: if (S_AXI_RREADY) rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM outputs decoded from the registered state.
  always_comb begin
    S_AXI_ARREADY = (rd_state == RD_ACC);
    S_AXI_RVALID  = (rd_state == RD_DATA);
  end

  // Read mux; write-only and unmapped offsets return zero.
  always_comb begin
    rd_word = '0;
    case (S_AXI_ARADDR)
      A_GIE:   rd_word = 32'(gie);
      A_IER:   rd_word = 32'(ier);
      A_ISR:   rd_word = 32'(isr);
      A_IPR:   rd_word = 32'(ipr);
      A_MODE:  rd_word = 32'(mode);
      A_THR:   rd_word = 32'(coal_thr);
      A_TMO:   rd_word = 32'(coal_tmo);
      default: rd_word = '0;
    endcase
  end

  // Read data register, loaded on the address handshake and held while RVALID.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET)             S_AXI_RDATA <= '0;
    else if (rd_state == RD_ACC)  S_AXI_RDATA <= rd_word;
  end

  // Source capture: hardware and software sets take priority over IACK.
  always_comb begin
    iack_bits = '0;
    iset_bits = '0;
    hw_set    = '0;
    if (wr_en && S_AXI_AWADDR == A_IACK)
      iack_bits = N'(strb_merge(32'd0, S_AXI_WDATA, S_AXI_WSTRB));
    if (wr_en && S_AXI_AWADDR == A_ISET)
      iset_bits = N'(strb_merge(32'd0, S_AXI_WDATA, S_AXI_WSTRB));
    for (int i = 0; i < N; i++)
      hw_set[i] = (mode[i] == MODE_EDGE) ? (intr_in[i] & ~intr_prev[i]) : intr_in[i];
    isr_nxt = (isr & ~iack_bits) | hw_set | iset_bits;
  end

  // Register file, status register and source history.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      gie       <= 1'b0;
      ier       <= '0;
      mode      <= '0;
      isr       <= '0;
      intr_prev <= '0;
      coal_thr  <= '0;
      coal_tmo  <= '0;
    end else begin
      intr_prev <= intr_in;
      isr       <= isr_nxt;
      if (wr_en) begin
        case (S_AXI_AWADDR)
          A_GIE:   gie      <= 1'(strb_merge(32'(gie), S_AXI_WDATA, S_AXI_WSTRB));
          A_IER:   ier      <= N'(strb_merge(32'(ier), S_AXI_WDATA, S_AXI_WSTRB));
          A_MODE:  mode     <= N'(strb_merge(32'(mode), S_AXI_WDATA, S_AXI_WSTRB));
          A_THR:   coal_thr <= CW'(strb_merge(32'(coal_thr), S_AXI_WDATA, S_AXI_WSTRB));
          A_TMO:   coal_tmo <= CW'(strb_merge(32'(coal_tmo), S_AXI_WDATA, S_AXI_WSTRB));
          default: ;
        endcase
      end
    end
  end

  axi_mm_intr_coalescer #(
    .C_NUM_OF_INTR (C_NUM_OF_INTR),
    .C_COAL_W      (C_COAL_W)
  ) u_coalescer (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .gie      (gie),
    .ipr      (ipr),
    .coal_thr (coal_thr),
    .coal_tmo (coal_tmo),
    .irq      (irq)
  );

endmodule

// File: tb/tb_axi_mm_intr_ctrl.sv
// Self-checking bench for axi_mm_intr_ctrl: AXI read/write scoreboards plus
// direct checks of irq timing and reset behaviour.
module tb_axi_mm_intr_ctrl;

  localparam int N = 4;

  localparam logic [5:0] R_GIE  = 6'h00;
  localparam logic [5:0] R_IER  = 6'h04;
  localparam logic [5:0] R_ISR  = 6'h08;
  localparam logic [5:0] R_IACK = 6'h0C;
  localparam logic [5:0] R_IPR  = 6'h10;
  localparam logic [5:0] R_MODE = 6'h14;
  localparam logic [5:0] R_ISET = 6'h18;
  localparam logic [5:0] R_THR  = 6'h1C;
  localparam logic [5:0] R_TMO  = 6'h20;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  intr_in;
  logic [5:0]    awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;

  int checks = 0;
  int errors = 0;

  string       rd_tag_q[$];
  logic [31:0] rd_exp_q[$];
  logic [1:0]  wr_exp_q[$];

  always #5 clk = ~clk;

  axi_mm_intr_ctrl #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6),
    .C_NUM_OF_INTR      (N),
    .C_COAL_W           (8)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .intr_in       (intr_in),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .irq           (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Write response scoreboard.
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (wr_exp_q.size() > 0) chk("bresp", 32'(bresp), 32'(wr_exp_q.pop_front()));
      else                     chk("b_unexpected", 32'd1, 32'd0);
    end
  end

  // Read data scoreboard.
  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (rd_exp_q.size() > 0) begin
        string t;
        t = rd_tag_q.pop_front();
        chk({t, "_rresp"}, 32'(rresp), 32'd0);
        chk(t, rdata, rd_exp_q.pop_front());
      end else begin
        chk("r_unexpected", 32'd1, 32'd0);
      end
    end
  end

  task automatic axi_write_p(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [N-1:0] pulse);
    bit got = 0;
    wr_exp_q.push_back(2'b00);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (awready) begin got = 1; break; end
    end
    if (!got) begin
      chk("aw_timeout", 32'd0, 32'd1);
      void'(wr_exp_q.pop_back());
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    chk("wready_with_awready", 32'(wready), 32'd1);
    intr_in = intr_in | pulse;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    intr_in = intr_in & ~pulse;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      if (wr_exp_q.size() == 0) begin got = 1; break; end
    end
    if (!got) begin
      chk("b_timeout", 32'd0, 32'd1);
      wr_exp_q.delete();
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d);
    axi_write_p(a, d, 4'hF, '0);
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] exp, input string tag);
    bit got = 0;
    rd_tag_q.push_back(tag);
    rd_exp_q.push_back(exp);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (arready) begin got = 1; break; end
    end
    if (!got) begin
      chk({tag, "_ar_timeout"}, 32'd0, 32'd1);
      void'(rd_tag_q.pop_back());
      void'(rd_exp_q.pop_back());
      arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      if (rd_exp_q.size() == 0) begin got = 1; break; end
    end
    if (!got) begin
      chk({tag, "_r_timeout"}, 32'd0, 32'd1);
      rd_tag_q.delete();
      rd_exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ch);
    @(negedge clk);
    intr_in[ch] = 1'b1;
    @(negedge clk);
    intr_in[ch] = 1'b0;
  endtask

  // One-cycle pulse on a channel; returns the number of rising edges, counting
  // the edge that samples the pulse as 1, until irq is seen high.
  task automatic pulse_lat(input int ch, output int lat);
    @(negedge clk);
    intr_in[ch] = 1'b1;
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      intr_in[ch] = 1'b0;
      if (irq) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] offs [9];
    int lat;
    bit got;
    offs = '{R_GIE, R_IER, R_ISR, R_IACK, R_IPR, R_MODE, R_ISET, R_THR, R_TMO};

    rst = 1'b1; intr_in = '0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_handshake", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    // 1: reset values and unmapped access
    for (int i = 0; i < 9; i++) axi_read(offs[i], 32'd0, $sformatf("t1_rd_%02h", offs[i]));
    axi_write(6'h3C, 32'hDEADBEEF);
    axi_read(6'h3C, 32'd0, "t1_unmapped");
    chk("t1_irq", 32'(irq), 32'd0);

    // 2: edge capture on ch0, irq latency, IACK
    axi_write(R_GIE, 32'h1);
    axi_write(R_IER, 32'h1);
    axi_write(R_MODE, 32'h1);
    pulse_lat(0, lat);
    chk("t2_irq_latency", 32'(lat), 32'd2);
    axi_read(R_ISR, 32'h1, "t2_isr");
    axi_read(R_IPR, 32'h1, "t2_ipr");
    axi_write(R_IACK, 32'h1);
    @(negedge clk);
    chk("t2_irq_after_iack", 32'(irq), 32'd0);
    axi_read(R_ISR, 32'h0, "t2_isr_clr");

    // 3: level capture on ch2 survives IACK while held high
    axi_write(R_MODE, 32'h0);
    axi_write(R_IER, 32'h4);
    @(negedge clk);
    intr_in[2] = 1'b1;
    idle(3);
    chk("t3_irq_level", 32'(irq), 32'd1);
    axi_write(R_IACK, 32'h4);
    axi_read(R_ISR, 32'h4, "t3_isr_reset");
    chk("t3_irq_held", 32'(irq), 32'd1);
    @(negedge clk);
    intr_in[2] = 1'b0;
    axi_write(R_IACK, 32'h4);
    @(negedge clk);
    chk("t3_irq_cleared", 32'(irq), 32'd0);
    axi_read(R_IPR, 32'h0, "t3_ipr_clr");

    // 4: count threshold, plus a write with no strobes that must be ignored
    axi_write(R_MODE, 32'hF);
    axi_write(R_THR, 32'h3);
    axi_write_p(R_THR, 32'h77, 4'h0, '0);
    axi_read(R_THR, 32'h3, "t4_thr_strb");
    axi_write(R_IER, 32'hF);
    pulse(0);
    idle(5);
    chk("t4_irq_after_1", 32'(irq), 32'd0);
    pulse(1);
    idle(5);
    chk("t4_irq_after_2", 32'(irq), 32'd0);
    pulse(3);
    idle(5);
    chk("t4_irq_after_3", 32'(irq), 32'd1);
    axi_read(R_ISR, 32'hB, "t4_isr");
    axi_write(R_IACK, 32'hF);
    @(negedge clk);
    chk("t4_irq_cleared", 32'(irq), 32'd0);

    // 5: timeout release, then software set with the channel disabled
    axi_write(R_THR, 32'h8);
    axi_write(R_TMO, 32'd10);
    axi_write(R_IER, 32'h1);
    pulse_lat(0, lat);
    chk("t5_tmo_latency", 32'(lat), 32'd11);
    axi_write(R_IACK, 32'h1);
    @(negedge clk);
    chk("t5_irq_cleared", 32'(irq), 32'd0);
    axi_write(R_IER, 32'h0);
    axi_write(R_ISET, 32'h2);
    axi_read(R_ISR, 32'h2, "t5_iset_isr");
    axi_read(R_IPR, 32'h0, "t5_iset_ipr");
    idle(3);
    chk("t5_iset_no_irq", 32'(irq), 32'd0);
    axi_write(R_IACK, 32'h2);
    axi_read(R_ISR, 32'h0, "t5_isr_clr");

    // 6: hardware set and IACK on the same bit in the same cycle
    axi_write_p(R_IACK, 32'h2, 4'hF, 4'h2);
    axi_read(R_ISR, 32'h2, "t6_set_wins");

    // 6: reset while a write response is pending
    bready = 1'b0;
    @(negedge clk);
    awaddr = R_GIE; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (awready) begin got = 1; break; end
    end
    chk("t6_aw_accept", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bvalid) begin got = 1; break; end
    end
    chk("t6_bvalid_pending", 32'(got), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_bvalid_after_rst", 32'(bvalid), 32'd0);
    chk("t6_irq_after_rst", 32'(irq), 32'd0);
    rst = 1'b0;
    bready = 1'b1;
    for (int i = 0; i < 9; i++) axi_read(offs[i], 32'd0, $sformatf("t6_rd_%02h", offs[i]));

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
